message_extractor: RTL and testbench
====================================

// Module: message_extractor
// PURPOSE
//  Splits a 64-bit Avalon-ST packet stream into individual length-prefixed messages.
//  Each packet carries a 2-byte message count, then per message a 2-byte length and the payload.
//  Fields are big-endian; in_data[63:56] is the first byte on the wire.
//  Each message is emitted as one 256-bit word with a byte mask, downstream of the packet receiver.
// PARAMETERS
//  none (data width 64, output width 256, message length range 8..32 bytes are fixed)
// PORTS
//  clk              in   1    single clock
//  reset            in   1    reset (synchronous, active-high)
//  in_valid         in   1    input beat valid
//  in_startofpacket in   1    first beat of packet
//  in_endofpacket   in   1    last beat of packet
//  in_error         in   1    beat/packet error
//  in_data          in   64   payload; byte0 = [63:56]
//  in_empty         in   3    unused bytes at LSB end; meaningful only with in_endofpacket
//  in_ready         out  1    sink ready
//  out_valid        out  1    one-cycle message strobe
//  out_data         out  256  message bytes, right-aligned
//  out_bytemask     out  32   valid-byte mask, bit i = out_data byte i
// BEHAVIOUR
//  - Interface: one clock, clk; reset is synchronous and active-high.
//  - Reset: out_valid=0, out_data=0, out_bytemask=0, in_ready=0, FSM->IDLE, all counters cleared.
//  - in_ready=1 every cycle after reset; no backpressure. Beat accepted when in_valid & in_ready.
//    A message is at least 10 wire bytes, so at most one message completes per beat.
//  - Per accepted beat, bytes 0..7 are processed in order.
//    On the end-of-packet beat, only 8-in_empty bytes are processed.
//  - FSM states and transitions:
//    - IDLE: waits for SOP.
//    - CNT_HI, CNT_LO: 16-bit message count.
//    - LEN_HI, LEN_LO: 16-bit message length.
//    - PAYLOAD: byte counter.
//    - DROP: discards bytes until next SOP.
//    - Any field may straddle a beat boundary (e.g. length 0x000e split 00|0e). The FSM state carries over.
//  - An SOP beat restarts parsing at CNT_HI from any state. Partial messages are discarded with no output.
//  - Count 0 -> DROP.
//  - Length <8 or >32 -> DROP for the rest of the packet, with no output for that message.
//  - When the count is exhausted, the FSM goes to DROP; trailing bytes are ignored.
//  - Payload: byte k of a message of length L is written to out_data byte (L-1-k).
//    The first byte is the most significant; bytes above L-1 are 0.
//  - On completion: out_bytemask=(1<<L)-1.
//  - out_valid rises for exactly 1 cycle, registered in the cycle after the edge that accepted the last payload byte.
//  - out_data/out_bytemask hold their last value while out_valid=0.
//  - in_error on an accepted beat: that beat is ignored and the FSM goes to DROP.
//    A message in progress is discarded.
//  - EOP before count/length/payload is complete: partial data is discarded, FSM->IDLE, no output.
//  - in_valid=0: state holds and nothing advances.
//  - Reset mid-message clears everything; no output is produced for that message.
// TESTING
//  - Stimulus: 15-beat packet, count 8, lengths 8,12,10,15,14,17,11,9, filled with bytes 62,68,70,7a,4d,38,31,5a.
//    The last beat is 5a5a000000000000 with empty=6.
//    Required: 8 out_valid pulses.
//    Masks: 000000ff, 00000fff, 000003ff, 00007fff, 00003fff, 0001ffff, 000007ff, 000001ff.
//    Each out_data is the low L bytes of the fill value.
//  - Split length (beat ...7a00 then 0e4d...) -> a 14-byte 0x4d message with mask 00003fff.
//  - 32-byte message (length 0x0020) -> mask ffffffff, all 256 bits valid. Length 0x0021 or 0x0007 -> no output, rest of packet dropped.
//  - in_error asserted mid-message -> no output for that packet; the next SOP packet parses normally.
//  - New SOP arrives before the previous packet finishes -> the old partial message is discarded and the new count is parsed.
//  - Reset asserted mid-payload -> outputs 0 the next cycle. The next packet after reset extracts correctly.

Source files
------------

// File: rtl/message_extractor.sv
// Splits a 64-bit Avalon-ST packet stream into length-prefixed messages,
// each emitted as one right-aligned 256-bit word with a byte mask.
module message_extractor (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic         in_startofpacket,
  input  logic         in_endofpacket,
  input  logic         in_error,
  input  logic [63:0]  in_data,
  input  logic [2:0]   in_empty,
  output logic         in_ready,
  output logic         out_valid,
  output logic [255:0] out_data,
  output logic [31:0]  out_bytemask
);

  typedef enum logic [2:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    LEN_HI,
    LEN_LO,
    PAYLOAD,
    DROP
  } state_t;

  state_t       state_q, state_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [7:0]   len_hi_q, len_hi_d;
  logic [5:0]   len_q, len_d;
  logic [5:0]   pos_q, pos_d;
  logic [255:0] acc_q, acc_d;

  logic         done_d;
  logic [255:0] data_d;
  logic [31:0]  mask_d;
  logic [3:0]   nbytes;
  logic [7:0]   b;
  logic [15:0]  len16;

  // All bytes of a beat are walked in order through an unrolled chain
  // of the byte-level parser; at most one message can complete per beat.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    pos_d    = pos_q;
    acc_d    = acc_q;
    done_d   = 1'b0;
    data_d   = '0;
    mask_d   = '0;
    nbytes   = 4'd8;
    b        = '0;
    len16    = '0;
    if (in_valid && in_ready) begin
      if (in_error) begin
        state_d = DROP;
      end else begin
        if (in_startofpacket) state_d = CNT_HI;
        if (in_endofpacket) nbytes = 4'd8 - {1'b0, in_empty};
        for (int i = 0; i < 8; i++) begin
          if (4'(i) < nbytes) begin
            b = in_data[63-8*i -: 8];
            unique case (state_d)
              CNT_HI: begin
                cnt_d[15:8] = b;
                state_d     = CNT_LO;
              end
              CNT_LO: begin
                cnt_d[7:0] = b;
                state_d    = (cnt_d == 16'd0) ? DROP : LEN_HI;
              end
              LEN_HI: begin
                len_hi_d = b;
                state_d  = LEN_LO;
              end
              LEN_LO: begin
                len16 = {len_hi_d, b};
                if (len16 < 16'd8 || len16 > 16'd32) begin
                  state_d = DROP;
                end else begin
                  len_d   = len16[5:0];
                  pos_d   = '0;
                  acc_d   = '0;
                  state_d = PAYLOAD;
                end
              end
              PAYLOAD: begin
                acc_d = {acc_d[247:0], b};
                pos_d = pos_d + 6'd1;
                if (pos_d == len_d) begin
                  done_d  = 1'b1;
                  data_d  = acc_d;
                  mask_d  = 32'hffff_ffff >> (6'd32 - len_d);
                  cnt_d   = cnt_d - 16'd1;
                  state_d = (cnt_d == 16'd0) ? DROP : LEN_HI;
                end
              end
              default: ;
            endcase
          end
        end
        // Anything still open at end of packet is truncated.
        if (in_endofpacket) state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      len_hi_q     <= '0;
      len_q        <= '0;
      pos_q        <= '0;
      acc_q        <= '0;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_bytemask <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_hi_q  <= len_hi_d;
      len_q     <= len_d;
      pos_q     <= pos_d;
      acc_q     <= acc_d;
      in_ready  <= 1'b1;
      out_valid <= done_d;
      if (done_d) begin
        out_data     <= data_d;
        out_bytemask <= mask_d;
      end
    end
  end

endmodule

// File: tb/tb_message_extractor.sv
// Directed bench for message_extractor: builds packets byte by byte,
// captures out_valid strobes and compares against hand-built messages.
module tb_message_extractor;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_startofpacket;
  logic         in_endofpacket;
  logic         in_error;
  logic [63:0]  in_data;
  logic [2:0]   in_empty;
  logic         in_ready;
  logic         out_valid;
  logic [255:0] out_data;
  logic [31:0]  out_bytemask;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   pkt[$];
  logic [255:0] cap_d[$];
  logic [31:0]  cap_m[$];
  logic [255:0] exp_d[$];
  logic [31:0]  exp_m[$];

  message_extractor dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_startofpacket (in_startofpacket),
    .in_endofpacket   (in_endofpacket),
    .in_error         (in_error),
    .in_data          (in_data),
    .in_empty         (in_empty),
    .in_ready         (in_ready),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_bytemask     (out_bytemask)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      cap_d.push_back(out_data);
      cap_m.push_back(out_bytemask);
    end
  end

  task automatic check(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic beat(input logic sop, input logic eop, input logic err,
                      input logic [63:0] d, input logic [2:0] e);
    in_valid         = 1'b1;
    in_startofpacket = sop;
    in_endofpacket   = eop;
    in_error         = err;
    in_data          = d;
    in_empty         = e;
    @(negedge clk);
    in_valid         = 1'b0;
    in_startofpacket = 1'b0;
    in_endofpacket   = 1'b0;
    in_error         = 1'b0;
    in_data          = '0;
    in_empty         = '0;
  endtask

  task automatic add_msg(input logic [15:0] len, input logic [7:0] fill,
                         input int n);
    pkt.push_back(len[15:8]);
    pkt.push_back(len[7:0]);
    for (int i = 0; i < n; i++) pkt.push_back(fill);
  endtask

  task automatic add_cnt(input logic [15:0] c);
    pkt.push_back(c[15:8]);
    pkt.push_back(c[7:0]);
  endtask

  task automatic expect_msg(input int len, input logic [7:0] fill);
    logic [255:0] d;
    logic [31:0]  m;
    d = '0;
    m = '0;
    for (int i = 0; i < len; i++) begin
      d[8*i +: 8] = fill;
      m[i]        = 1'b1;
    end
    exp_d.push_back(d);
    exp_m.push_back(m);
  endtask

  task automatic send_pkt(input int err_beat, input int max_beats,
                          input int gap);
    int nb;
    int sz;
    logic [63:0] d;
    logic [2:0]  e;
    sz = pkt.size();
    nb = (sz + 7) / 8;
    for (int bt = 0; bt < nb && bt < max_beats; bt++) begin
      d = '0;
      for (int k = 0; k < 8; k++)
        if (bt * 8 + k < sz) d[63-8*k -: 8] = pkt[bt*8+k];
      e = (bt == nb - 1) ? 3'(nb * 8 - sz) : 3'd0;
      beat(bt == 0, bt == nb - 1, bt == err_beat, d, e);
      if (gap != 0) idle(1);
    end
    pkt.delete();
  endtask

  task automatic compare(input string tag);
    idle(4);
    check({tag, "_count"}, 256'(cap_d.size()), 256'(exp_d.size()));
    for (int i = 0; i < exp_d.size(); i++) begin
      if (i < cap_d.size()) begin
        check($sformatf("%s_data%0d", tag, i), cap_d[i], exp_d[i]);
        check($sformatf("%s_mask%0d", tag, i), 256'(cap_m[i]),
              256'(exp_m[i]));
      end
    end
    if (exp_d.size() > 0) begin
      check({tag, "_hold_data"}, out_data, exp_d[exp_d.size()-1]);
      check({tag, "_hold_valid"}, 256'(out_valid), 256'(0));
    end
    cap_d.delete();
    cap_m.delete();
    exp_d.delete();
    exp_m.delete();
  endtask

  initial begin
    reset            = 1'b1;
    in_valid         = 1'b0;
    in_startofpacket = 1'b0;
    in_endofpacket   = 1'b0;
    in_error         = 1'b0;
    in_data          = '0;
    in_empty         = '0;
    idle(3);
    check("rst_valid", 256'(out_valid), 256'(0));
    check("rst_data", out_data, 256'(0));
    check("rst_mask", 256'(out_bytemask), 256'(0));
    check("rst_ready", 256'(in_ready), 256'(0));
    reset = 1'b0;
    idle(1);
    check("ready_up", 256'(in_ready), 256'(1));

    // 15-beat packet with eight messages, last beat 5a5a.. empty=6
    add_cnt(16'd8);
    add_msg(16'd8,  8'h62, 8);  expect_msg(8,  8'h62);
    add_msg(16'd12, 8'h68, 12); expect_msg(12, 8'h68);
    add_msg(16'd10, 8'h70, 10); expect_msg(10, 8'h70);
    add_msg(16'd15, 8'h7a, 15); expect_msg(15, 8'h7a);
    add_msg(16'd14, 8'h4d, 14); expect_msg(14, 8'h4d);
    add_msg(16'd17, 8'h38, 17); expect_msg(17, 8'h38);
    add_msg(16'd11, 8'h31, 11); expect_msg(11, 8'h31);
    add_msg(16'd9,  8'h5a, 9);  expect_msg(9,  8'h5a);
    check("main_len", 256'(pkt.size()), 256'(114));
    send_pkt(-1, 100, 0);
    compare("main");

    // length 0x000e split across beats as 00|0e, idle gaps between beats
    add_cnt(16'd2);
    add_msg(16'd11, 8'h7a, 11); expect_msg(11, 8'h7a);
    add_msg(16'd14, 8'h4d, 14); expect_msg(14, 8'h4d);
    send_pkt(-1, 100, 1);
    compare("split");

    add_cnt(16'd2);
    add_msg(16'd32, 8'h62, 32); expect_msg(32, 8'h62);
    add_msg(16'd8,  8'h31, 8);  expect_msg(8,  8'h31);
    send_pkt(-1, 100, 0);
    compare("len32");

    add_cnt(16'd2);
    add_msg(16'd33, 8'h68, 33);
    add_msg(16'd8,  8'h70, 8);
    send_pkt(-1, 100, 0);
    compare("len33");

    add_cnt(16'd2);
    add_msg(16'd7, 8'h7a, 7);
    add_msg(16'd8, 8'h4d, 8);
    send_pkt(-1, 100, 0);
    compare("len7");

    add_cnt(16'd0);
    add_msg(16'd8, 8'h38, 8);
    send_pkt(-1, 100, 0);
    compare("cnt0");

    add_cnt(16'd1);
    add_msg(16'd16, 8'h68, 16);
    send_pkt(1, 100, 0);
    compare("error");

    add_cnt(16'd1);
    add_msg(16'd8, 8'h70, 8); expect_msg(8, 8'h70);
    send_pkt(-1, 100, 0);
    compare("after_err");

    // truncated packet, then a new SOP; trailing bytes after count ignored
    add_cnt(16'd1);
    add_msg(16'd20, 8'h38, 20);
    send_pkt(-1, 2, 0);
    add_cnt(16'd1);
    add_msg(16'd9, 8'h5a, 9); expect_msg(9, 8'h5a);
    add_msg(16'd8, 8'h62, 8);
    send_pkt(-1, 100, 0);
    compare("resop");

    add_cnt(16'd1);
    add_msg(16'd18, 8'h4d, 18);
    send_pkt(-1, 2, 0);
    reset = 1'b1;
    idle(1);
    check("mid_rst_valid", 256'(out_valid), 256'(0));
    check("mid_rst_data", out_data, 256'(0));
    check("mid_rst_mask", 256'(out_bytemask), 256'(0));
    reset = 1'b0;
    idle(1);
    beat(1'b0, 1'b1, 1'b0, 64'h4d4d4d4d4d4d4d4d, 3'd2);
    compare("post_rst_tail");

    add_cnt(16'd1);
    add_msg(16'd12, 8'h4d, 12); expect_msg(12, 8'h4d);
    send_pkt(-1, 100, 0);
    compare("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
